// File: rtl/pht_upd_queue.sv
// In-order PHT update queue: records {index, pred} per fetched branch and drives the PHT write port on retirement.
// Optional build macro PHT_UPDQ_PERF_CNT_EN enables saturating retired-branch / mispredict counters.
module pht_upd_queue #(
  parameter int unsigned LOG_INDEX = 10,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned LOG_DEPTH = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 bp_alloc_vld_i,
  input  logic [LOG_INDEX-1:0] bp_alloc_index_i,
  input  logic                 bp_alloc_pred_i,
  output logic                 bp_alloc_rdy_o,
  output logic [LOG_DEPTH-1:0] bp_alloc_tag_o,
  input  logic                 cm_br_vld_i,
  input  logic                 cm_br_dir_i,
  input  logic                 ex_flush_i,
  output logic [LOG_INDEX-1:0] pht_wt_index_o,
  output logic                 pht_cm_brdir_we_o,
  output logic                 pht_cm_brdir_o,
  output logic                 cm_mispred_o,
  output logic [LOG_DEPTH:0]   updq_cnt_o,
  output logic                 updq_err_o,
  output logic [31:0]          perf_br_cnt_o,
  output logic [31:0]          perf_mispred_cnt_o
);

  localparam int unsigned PW = LOG_DEPTH + 1;

  typedef struct packed {
    logic [LOG_INDEX-1:0] index;
    logic                 pred;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [PW-1:0]        cnt_q;
  logic [LOG_DEPTH-1:0] tag_q;
  logic                 rdy_q;
  logic                 we_q, mispred_q, err_q, brdir_q;
  logic [LOG_INDEX-1:0] wt_index_q;

  logic   empty_c, full_d_c, alloc_c, write_c, retire_c, mispred_c, err_c;
  entry_t head_entry_c;

  assign empty_c      = (head_q == tail_q);
  assign head_entry_c = mem_q[head_q[LOG_DEPTH-1:0]];
  assign alloc_c      = bp_alloc_vld_i & rdy_q;
  assign retire_c     = cm_br_vld_i & ~empty_c;
  assign err_c        = cm_br_vld_i & empty_c;
  assign mispred_c    = retire_c & (head_entry_c.pred != cm_br_dir_i);
  // A mispredict or flush squashes everything younger, including a same-cycle allocation.
  assign write_c      = alloc_c & ~mispred_c & ~ex_flush_i;

  // Next pointer state.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (retire_c) head_d = head_q + PW'(1);
    if (write_c)  tail_d = tail_q + PW'(1);
    if (mispred_c || ex_flush_i) tail_d = head_d;
  end

  assign full_d_c = (head_d[PW-1] != tail_d[PW-1]) &&
                    (head_d[LOG_DEPTH-1:0] == tail_d[LOG_DEPTH-1:0]);

  // Entry storage, written at the tail slot.
  always_ff @(posedge clock) begin
    if (write_c) begin
      mem_q[tail_q[LOG_DEPTH-1:0]] <= '{index: bp_alloc_index_i, pred: bp_alloc_pred_i};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      tag_q      <= '0;
      rdy_q      <= 1'b0;
      we_q       <= 1'b0;
      mispred_q  <= 1'b0;
      err_q      <= 1'b0;
      brdir_q    <= 1'b0;
      wt_index_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= tail_d - head_d;
      tag_q     <= tail_d[LOG_DEPTH-1:0];
      rdy_q     <= ~full_d_c;
      we_q      <= retire_c;
      mispred_q <= mispred_c;
      err_q     <= err_c;
      // Index and direction hold their last value between updates.
      if (retire_c) begin
        wt_index_q <= head_entry_c.index;
        brdir_q    <= cm_br_dir_i;
      end
    end
  end

`ifdef PHT_UPDQ_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_mispred_q;

  // Saturating event counters; not cleared by flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_br_q      <= '0;
      perf_mispred_q <= '0;
    end else begin
      if (retire_c && (perf_br_q != 32'hFFFF_FFFF))       perf_br_q      <= perf_br_q + 32'd1;
      if (mispred_c && (perf_mispred_q != 32'hFFFF_FFFF)) perf_mispred_q <= perf_mispred_q + 32'd1;
    end
  end

  assign perf_br_cnt_o      = perf_br_q;
  assign perf_mispred_cnt_o = perf_mispred_q;
`else
  assign perf_br_cnt_o      = 32'h0;
  assign perf_mispred_cnt_o = 32'h0;
`endif

  assign bp_alloc_rdy_o    = rdy_q;
  assign bp_alloc_tag_o    = tag_q;
  assign pht_wt_index_o    = wt_index_q;
  assign pht_cm_brdir_we_o = we_q;
  assign pht_cm_brdir_o    = brdir_q;
  assign cm_mispred_o      = mispred_q;
  assign updq_cnt_o        = cnt_q;
  assign updq_err_o        = err_q;

endmodule

// File: tb/tb_pht_upd_queue.sv
// Scoreboard bench for pht_upd_queue: stimulus pushes hand-computed PHT updates, a monitor pops and compares.
module tb_pht_upd_queue;

  logic        clock, reset_n;
  logic        bp_alloc_vld_i, bp_alloc_pred_i, bp_alloc_rdy_o;
  logic [9:0]  bp_alloc_index_i;
  logic [2:0]  bp_alloc_tag_o;
  logic        cm_br_vld_i, cm_br_dir_i, ex_flush_i;
  logic [9:0]  pht_wt_index_o;
  logic        pht_cm_brdir_we_o, pht_cm_brdir_o, cm_mispred_o, updq_err_o;
  logic [3:0]  updq_cnt_o;
  logic [31:0] perf_br_cnt_o, perf_mispred_cnt_o;

  pht_upd_queue dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .bp_alloc_vld_i     (bp_alloc_vld_i),
    .bp_alloc_index_i   (bp_alloc_index_i),
    .bp_alloc_pred_i    (bp_alloc_pred_i),
    .bp_alloc_rdy_o     (bp_alloc_rdy_o),
    .bp_alloc_tag_o     (bp_alloc_tag_o),
    .cm_br_vld_i        (cm_br_vld_i),
    .cm_br_dir_i        (cm_br_dir_i),
    .ex_flush_i         (ex_flush_i),
    .pht_wt_index_o     (pht_wt_index_o),
    .pht_cm_brdir_we_o  (pht_cm_brdir_we_o),
    .pht_cm_brdir_o     (pht_cm_brdir_o),
    .cm_mispred_o       (cm_mispred_o),
    .updq_cnt_o         (updq_cnt_o),
    .updq_err_o         (updq_err_o),
    .perf_br_cnt_o      (perf_br_cnt_o),
    .perf_mispred_cnt_o (perf_mispred_cnt_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [9:0] idx;
    logic       dir;
    logic       mis;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  task automatic expect_upd(input logic [9:0] idx, input logic dir, input logic mis);
    exp_q.push_back('{idx: idx, dir: dir, mis: mis});
  endtask

  // One clock of stimulus: drive after a falling edge, return at the next falling edge.
  task automatic step(input logic a, input logic [9:0] idx, input logic p,
                      input logic r, input logic d, input logic f);
    bp_alloc_vld_i   = a;
    bp_alloc_index_i = idx;
    bp_alloc_pred_i  = p;
    cm_br_vld_i      = r;
    cm_br_dir_i      = d;
    ex_flush_i       = f;
    @(negedge clock);
    bp_alloc_vld_i = 1'b0;
    cm_br_vld_i    = 1'b0;
    ex_flush_i     = 1'b0;
  endtask

  // Monitor: every PHT write strobe must match the oldest expected update.
  always @(negedge clock) begin
    if (reset_n) begin
      if (pht_cm_brdir_we_o) begin
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL upd_unexpected: got idx 0x%0h dir %0b mis %0b, expected no update",
                   pht_wt_index_o, pht_cm_brdir_o, cm_mispred_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (pht_wt_index_o === e.idx && pht_cm_brdir_o === e.dir && cm_mispred_o === e.mis)
            pass_cnt++;
          else
            $display("FAIL upd_data: got idx 0x%0h dir %0b mis %0b, expected idx 0x%0h dir %0b mis %0b",
                     pht_wt_index_o, pht_cm_brdir_o, cm_mispred_o, e.idx, e.dir, e.mis);
        end
      end else if (cm_mispred_o !== 1'b0) begin
        chk_cnt++;
        $display("FAIL mispred_no_we: got %0b expected 0", cm_mispred_o);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    bp_alloc_vld_i = 1'b0; bp_alloc_index_i = '0; bp_alloc_pred_i = 1'b0;
    cm_br_vld_i = 1'b0; cm_br_dir_i = 1'b0; ex_flush_i = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_rdy", 32'(bp_alloc_rdy_o), 32'd0);
    chk("reset_cnt", 32'(updq_cnt_o), 32'd0);
    chk("reset_we",  32'(pht_cm_brdir_we_o), 32'd0);
    chk("reset_err", 32'(updq_err_o), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rdy_after_reset", 32'(bp_alloc_rdy_o), 32'd1);
    chk("tag_after_reset", 32'(bp_alloc_tag_o), 32'd0);

    // Single alloc / correct retire.
    step(1'b1, 10'h155, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_cnt_after_alloc", 32'(updq_cnt_o), 32'd1);
    chk("t1_tag_after_alloc", 32'(bp_alloc_tag_o), 32'd1);
    expect_upd(10'h155, 1'b1, 1'b0);
    step(1'b0, 10'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t1_cnt_after_retire", 32'(updq_cnt_o), 32'd0);
    step(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fill to full; alloc while full is dropped even with a same-cycle retire.
    for (int i = 0; i < 8; i++) step(1'b1, 10'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_full_rdy", 32'(bp_alloc_rdy_o), 32'd0);
    chk("t2_full_cnt", 32'(updq_cnt_o), 32'd8);
    expect_upd(10'h0, 1'b0, 1'b0);
    step(1'b1, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_cnt_drop_full", 32'(updq_cnt_o), 32'd7);
    chk("t2_rdy_after_pop", 32'(bp_alloc_rdy_o), 32'd1);
    for (int i = 1; i < 8; i++) begin
      expect_upd(10'(i), 1'b0, 1'b0);
      step(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("t2_cnt_drained", 32'(updq_cnt_o), 32'd0);

    // Mispredict squashes younger entries and a same-cycle alloc.
    step(1'b1, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_cnt_three", 32'(updq_cnt_o), 32'd3);
    expect_upd(10'd3, 1'b0, 1'b1);
    step(1'b1, 10'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_cnt_squashed", 32'(updq_cnt_o), 32'd0);
    step(1'b0, 10'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t3_err_pulse", 32'(updq_err_o), 32'd1);
    chk("t3_we_on_empty", 32'(pht_cm_brdir_we_o), 32'd0);
    step(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_err_cleared", 32'(updq_err_o), 32'd0);

    // Interleaved alloc+retire at occupancy 2 across pointer wrap.
    step(1'b1, 10'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h101, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      expect_upd(10'(10'h100 + k), 1'(k & 1), 1'b0);
      step(1'b1, 10'(10'h102 + k), 1'(k & 1), 1'b1, 1'(k & 1), 1'b0);
    end
    chk("t4_cnt_steady", 32'(updq_cnt_o), 32'd2);
    expect_upd(10'h114, 1'b0, 1'b0);
    step(1'b0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_upd(10'h115, 1'b1, 1'b0);
    step(1'b0, 10'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4_cnt_drained", 32'(updq_cnt_o), 32'd0);

    // Flush with same-cycle retire and alloc.
    step(1'b1, 10'h2AA, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h2AB, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_upd(10'h2AA, 1'b0, 1'b0);
    step(1'b1, 10'h2AC, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t5_cnt_flushed", 32'(updq_cnt_o), 32'd0);
    chk("t5_rdy_flushed", 32'(bp_alloc_rdy_o), 32'd1);
    step(1'b0, 10'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_err_after_flush", 32'(updq_err_o), 32'd1);
    step(1'b0, 10'h0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef PHT_UPDQ_PERF_CNT_EN
    chk("perf_br", perf_br_cnt_o, 32'd33);
    chk("perf_mispred", perf_mispred_cnt_o, 32'd1);
`else
    chk("perf_br_tied", perf_br_cnt_o, 32'd0);
    chk("perf_mispred_tied", perf_mispred_cnt_o, 32'd0);
`endif
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
